// File: rtl/instr_encoder.sv
// RV32I instruction encoder / program loader: packs field sets into 32-bit words paired with
// incrementing instruction-memory addresses. Optional immediate range checking: ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned PROG_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [15:0] PW  = 16'(PROG_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        ov_q, ov_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] oaddr_q, oaddr_d;
  logic        err_q, err_d;

  logic [31:0] enc_word;
  logic        fmt_bad;
  logic        range_bad;
  logic        accept;
  logic        handoff;

  always_comb begin
    enc_word = NOP;
    fmt_bad  = 1'b0;
    case (fmt)
      4'd0: enc_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      4'd1: begin
        // shifts carry funct7 in the upper immediate bits
        if (funct3 == 3'b001 || funct3 == 3'b101)
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011};
        else
          enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      end
      4'd2: enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      4'd3: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      4'd4: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      4'd5: enc_word = {imm[31:12], rd, 7'b0110111};
      4'd6: enc_word = {imm[31:12], rd, 7'b0010111};
      4'd7: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      4'd8: enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic s12_ok, b13_ok, j21_ok, u_ok;
  assign s12_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j21_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_ok   = ~(|imm[11:0]);

  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      4'd1, 4'd2, 4'd3, 4'd8: range_bad = ~s12_ok;
      4'd4:                   range_bad = ~b13_ok;
      4'd5, 4'd6:             range_bad = ~u_ok;
      4'd7:                   range_bad = ~j21_ok;
      default:                range_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm0;
  assign unused_imm0 = imm[0];
  assign range_bad   = 1'b0;
`endif

  assign in_ready = (state_q == S_RUN) && (cnt_q < PW) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = ov_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ov_d    = ov_q;
    instr_d = instr_q;
    oaddr_d = oaddr_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          addr_d  = BASE_ADDR;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (handoff && cnt_q == PW) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (handoff) ov_d = 1'b0;

    if (accept) begin
      ov_d    = 1'b1;
      instr_d = (fmt_bad || range_bad) ? NOP : enc_word;
      oaddr_d = addr_q;
      addr_d  = addr_q + 32'd4;
      cnt_d   = cnt_q + 16'd1;
      if (fmt_bad || range_bad) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      ov_q    <= 1'b0;
      instr_q <= '0;
      oaddr_q <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ov_q    <= ov_d;
      instr_q <= instr_d;
      oaddr_q <= oaddr_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = ov_q;
  assign out_instr = instr_q;
  assign out_addr  = oaddr_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (4-word runs, base address 0).
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned PW   = 4;

  logic        clk, reset, start, in_valid, in_ready;
  logic [3:0]  fmt;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        done, err;

  int checks   = 0;
  int failures = 0;

  instr_encoder #(.BASE_ADDR(BASE), .PROG_WORDS(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_fields(input logic [3:0] f, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] im);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Presents a field set, waits (bounded) for acceptance, returns #1 after the accepting edge.
  task automatic push(input logic [3:0] f, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im);
    bit ok;
    int n;
    @(negedge clk);
    set_fields(f, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      if (in_ready) ok = 1'b1;
      else begin @(negedge clk); n++; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL push_timeout in_ready got=%b exp=1", in_ready); end
    else begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
    checks++; if (out_addr !== BASE) begin failures++; $display("FAIL rst_out_addr got=%h exp=%h", out_addr, BASE); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_done_err got=%b%b exp=00", done, err); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_no_start in_ready got=%b exp=0", in_ready); end
  endtask

  task automatic test_stall();
    do_start();
    checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL run_entry ready/done got=%b%b exp=10", in_ready, done); end
    push(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0050_0093 || out_addr !== BASE)
      begin failures++; $display("FAIL i_alu got v=%b %h @%h exp v=1 00500093 @%h", out_valid, out_instr, out_addr, BASE); end
    push(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    checks++; if (out_instr !== 32'h4020_81B3 || out_addr !== BASE + 32'd4)
      begin failures++; $display("FAIL r_type got %h @%h exp 402081b3 @%h", out_instr, out_addr, BASE + 32'd4); end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h4020_81B3 || out_addr !== BASE + 32'd4 || in_ready !== 1'b0)
        begin failures++; $display("FAIL stall_hold c=%0d got v=%b %h @%h rdy=%b exp v=1 402081b3 @4 rdy=0", c, out_valid, out_instr, out_addr, in_ready); end
    end
    out_ready = 1'b1;
    push(4'd5, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    checks++; if (out_instr !== 32'h1234_5137 || out_addr !== BASE + 32'd8)
      begin failures++; $display("FAIL lui got %h @%h exp 12345137 @%h", out_instr, out_addr, BASE + 32'd8); end
    push(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    checks++; if (out_instr !== 32'h0020_8463 || out_addr !== BASE + 32'hC)
      begin failures++; $display("FAIL branch got %h @%h exp 00208463 @%h", out_instr, out_addr, BASE + 32'hC); end
    checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL full_not_done ready/done got=%b%b exp=00", in_ready, done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL run1_done done/valid got=%b%b exp=10", done, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  fa [4] = '{4'd7, 4'd3, 4'd2, 4'd1};
    logic [4:0]  da [4] = '{5'd1, 5'd0, 5'd5, 5'd1};
    logic [4:0]  s1a[4] = '{5'd0, 5'd1, 5'd1, 5'd2};
    logic [4:0]  s2a[4] = '{5'd0, 5'd2, 5'd0, 5'd0};
    logic [2:0]  f3a[4] = '{3'd0, 3'd2, 3'd2, 3'd5};
    logic [6:0]  f7a[4] = '{7'd0, 7'd0, 7'd0, 7'h20};
    logic [31:0] ima[4] = '{32'h800, 32'd12, 32'hFFFF_FFFC, 32'd3};
    logic [31:0] exa[4] = '{32'h0010_00EF, 32'h0020_A623, 32'hFFC0_A283, 32'h4031_5093};
    do_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_fields(fa[i], da[i], s1a[i], s2a[i], f3a[i], f7a[i], ima[i]);
      in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_instr !== exa[i] || out_addr !== BASE + 32'(4 * i))
        begin failures++; $display("FAIL b2b_word i=%0d got v=%b %h @%h exp v=1 %h @%h", i, out_valid, out_instr, out_addr, exa[i], BASE + 32'(4 * i)); end
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
  endtask

  task automatic test_illegal();
    do_start();
    push(4'd8, 5'd0, 5'd1, 5'd0, 3'd7, 7'd0, 32'd0);
    checks++; if (out_instr !== 32'h0000_8067 || out_addr !== BASE || err !== 1'b0)
      begin failures++; $display("FAIL jalr got %h @%h err=%b exp 00008067 @%h err=0", out_instr, out_addr, err, BASE); end
    do_start();
    push(4'd12, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5);
    checks++; if (out_instr !== 32'h0000_0013 || out_addr !== BASE + 32'd4 || err !== 1'b1)
      begin failures++; $display("FAIL illegal_fmt got %h @%h err=%b exp 00000013 @%h err=1", out_instr, out_addr, err, BASE + 32'd4); end
    push(4'd6, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    checks++; if (out_instr !== 32'h0000_1197 || out_addr !== BASE + 32'd8 || err !== 1'b1)
      begin failures++; $display("FAIL auipc_sticky got %h @%h err=%b exp 00001197 @%h err=1", out_instr, out_addr, err, BASE + 32'd8); end
    push(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL run3_end done/err got=%b%b exp=11", done, err); end
    do_start();
    checks++; if (err !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL start_clears done/err got=%b%b exp=00", done, err); end
  endtask

  task automatic test_range();
    push(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
    checks++; if (out_instr !== 32'h7FF0_0093 || out_addr !== BASE || err !== 1'b0)
      begin failures++; $display("FAIL imm_max got %h @%h err=%b exp 7ff00093 @%h err=0", out_instr, out_addr, err, BASE); end
    push(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
    checks++; if (out_instr !== 32'h0000_0013 || err !== 1'b1)
      begin failures++; $display("FAIL imm_range got %h err=%b exp 00000013 err=1", out_instr, err); end
`else
    checks++; if (out_instr !== 32'h0000_0093 || err !== 1'b0)
      begin failures++; $display("FAIL imm_trunc got %h err=%b exp 00000093 err=0", out_instr, err); end
`endif
  endtask

  task automatic test_reset_midrun();
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_addr !== BASE || out_instr !== 32'h0)
      begin failures++; $display("FAIL midrun_reset got v=%b rdy=%b %h @%h exp v=0 rdy=0 0 @%h", out_valid, in_ready, out_instr, out_addr, BASE); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL midrun_reset done/err got=%b%b exp=00", done, err); end
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", in_ready); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_range();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
